// File: rtl/nn_pkg.sv
// Shared definitions for the neuron-layer datapath blocks: default word
// width, the serializer state encoding and the counter-width helper.
package nn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Width of an index counter able to hold 0..n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_output_serializer.sv
// Parallel-to-serial converter after a neuron layer. A frame of NEURONS_NUM
// words is captured when i_data_in_valid[0] is high and replayed one word per
// clock, neuron 0 first. Word 0 is registered out at the capture edge, so a
// frame occupies exactly NEURONS_NUM consecutive valid cycles. A capture that
// arrives while the last word is on the bus chains the next frame with no gap;
// any earlier capture during a frame is dropped and flagged with o_overrun.
module layer_output_serializer
  import nn_pkg::*;
#(
  parameter int NEURONS_NUM = 30,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NEURONS_NUM-1:0]            i_data_in_valid,
  input  logic [NEURONS_NUM*DATA_WIDTH-1:0] i_data_in,
  output logic                              o_data_out_valid,
  output logic [DATA_WIDTH-1:0]             o_data_out,
  output logic                              o_last,
  output logic                              o_busy,
  output logic                              o_overrun,
  output logic                              o_valid_err
);

  localparam int FLAT_W    = NEURONS_NUM * DATA_WIDTH;
  localparam int CNT_WIDTH = cnt_width(NEURONS_NUM);

  // Index of the final word and of the word just before it.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(NEURONS_NUM - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_PENULT = CNT_WIDTH'(NEURONS_NUM - 2);

  // Core state: FSM, shift register holding the words not yet emitted, and
  // the index of the word currently presented on o_data_out.
  ser_state_e               state_q, state_d;
  logic [FLAT_W-1:0]        sr_q, sr_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

  // Output registers and their next values.
  logic [DATA_WIDTH-1:0]    dout_q, dout_d;
  logic                     vld_q, vld_d;
  logic                     last_q, last_d;
  logic                     busy_q, busy_d;
  logic                     ovr_q, ovr_d;
  logic                     err_q, err_d;

  logic                     capture;
  logic                     valid_mismatch;

  assign capture        = i_data_in_valid[0];
  assign valid_mismatch = (|i_data_in_valid) & ~(&i_data_in_valid);

  // Next-state, shift/counter update and registered-output values.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dout_d  = '0;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    busy_d  = 1'b0;
    ovr_d   = 1'b0;
    err_d   = err_q | valid_mismatch;

    unique case (state_q)
      IDLE: begin
        if (capture) begin
          // Word 0 goes straight to the output; the rest waits in sr.
          state_d = SHIFT;
          sr_d    = {{DATA_WIDTH{1'b0}}, i_data_in[FLAT_W-1:DATA_WIDTH]};
          cnt_d   = '0;
          dout_d  = i_data_in[DATA_WIDTH-1:0];
          vld_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end

      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          // Last word is on the bus: chain a new frame or go idle.
          if (capture) begin
            state_d = SHIFT;
            sr_d    = {{DATA_WIDTH{1'b0}}, i_data_in[FLAT_W-1:DATA_WIDTH]};
            cnt_d   = '0;
            dout_d  = i_data_in[DATA_WIDTH-1:0];
            vld_d   = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            sr_d    = '0;
            cnt_d   = '0;
          end
        end else begin
          // Mid-frame: advance one word; a capture here cannot be accepted.
          sr_d   = {{DATA_WIDTH{1'b0}}, sr_q[FLAT_W-1:DATA_WIDTH]};
          cnt_d  = cnt_q + CNT_WIDTH'(1);
          dout_d = sr_q[DATA_WIDTH-1:0];
          vld_d  = 1'b1;
          busy_d = 1'b1;
          last_d = (cnt_q == CNT_PENULT);
          ovr_d  = capture;
        end
      end

      default: begin
        state_d = IDLE;
        sr_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, shift register and word counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output registers, including the sticky valid-mismatch flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      ovr_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
      last_q <= last_d;
      busy_q <= busy_d;
      ovr_q  <= ovr_d;
      err_q  <= err_d;
    end
  end

  assign o_data_out_valid = vld_q;
  assign o_data_out       = dout_q;
  assign o_last           = last_q;
  assign o_busy           = busy_q;
  assign o_overrun        = ovr_q;
  assign o_valid_err      = err_q;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed bench for layer_output_serializer: a 4-word instance for frame,
// chaining, overrun, reset and valid-mismatch cases, and a 30-word instance
// for a long random frame.
module tb_layer_output_serializer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 4-word instance
  logic [3:0]   v4 = '0;
  logic [63:0]  d4 = '0;
  logic         vld4, last4, busy4, ovr4, err4;
  logic [15:0]  q4;

  layer_output_serializer #(.NEURONS_NUM(4), .DATA_WIDTH(16)) u4 (
    .clk(clk), .reset_n(reset_n),
    .i_data_in_valid(v4), .i_data_in(d4),
    .o_data_out_valid(vld4), .o_data_out(q4), .o_last(last4),
    .o_busy(busy4), .o_overrun(ovr4), .o_valid_err(err4)
  );

  // 30-word instance
  logic [29:0]  v30 = '0;
  logic [479:0] d30 = '0;
  logic         vld30, last30, busy30, ovr30, err30;
  logic [15:0]  q30;
  logic [15:0]  words30 [30];

  layer_output_serializer #(.NEURONS_NUM(30), .DATA_WIDTH(16)) u30 (
    .clk(clk), .reset_n(reset_n),
    .i_data_in_valid(v30), .i_data_in(d30),
    .o_data_out_valid(vld30), .o_data_out(q30), .o_last(last30),
    .o_busy(busy30), .o_overrun(ovr30), .o_valid_err(err30)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle4(input string tag);
    check({tag, ".vld"},  vld4,  1'b0);
    check({tag, ".data"}, q4,    16'h0);
    check({tag, ".last"}, last4, 1'b0);
    check({tag, ".busy"}, busy4, 1'b0);
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    tick(); tick();
    check_idle4("rst");
    check("rst.ovr", ovr4, 1'b0);
    check("rst.err", err4, 1'b0);
    reset_n = 1'b1;
    tick();

    // Single frame: words 1..4, last only with 4
    v4 = 4'hF; d4 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    tick();
    v4 = '0;
    for (int k = 0; k < 4; k++) begin
      check("single.vld",  vld4,  1'b1);
      check("single.data", q4,    16'(k + 1));
      check("single.last", last4, (k == 3));
      check("single.busy", busy4, 1'b1);
      check("single.ovr",  ovr4,  1'b0);
      tick();
    end
    check_idle4("single.after");
    check("single.err", err4, 1'b0);
    tick();

    // Back-to-back: second frame captured while word 4 is on the bus
    v4 = 4'hF; d4 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    tick();
    v4 = '0;
    for (int k = 0; k < 8; k++) begin
      check("b2b.vld",  vld4,  1'b1);
      check("b2b.data", q4,    16'(k + 1));
      check("b2b.last", last4, (k == 3 || k == 7));
      check("b2b.busy", busy4, 1'b1);
      check("b2b.ovr",  ovr4,  1'b0);
      if (k == 3) begin
        v4 = 4'hF; d4 = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
      end else begin
        v4 = '0;
      end
      tick();
    end
    check_idle4("b2b.after");
    tick();

    // Overrun: second capture one cycle after the first is dropped
    v4 = 4'hF; d4 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    tick();
    d4 = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
    for (int k = 0; k < 4; k++) begin
      if (k >= 1) v4 = '0;
      check("ovr.vld",   vld4,  1'b1);
      check("ovr.data",  q4,    16'(k + 1));
      check("ovr.last",  last4, (k == 3));
      check("ovr.pulse", ovr4,  (k == 1));
      tick();
    end
    check_idle4("ovr.after");
    check("ovr.after.pulse", ovr4, 1'b0);
    tick();
    check_idle4("ovr.idle");

    // Reset mid-frame after word 2, then a fresh frame
    v4 = 4'hF; d4 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    tick();
    v4 = '0;
    check("rstmid.w1", q4, 16'h0001);
    tick();
    check("rstmid.w2", q4, 16'h0002);
    reset_n = 1'b0;
    tick();
    check_idle4("rstmid.inrst");
    tick();
    reset_n = 1'b1;
    tick();
    check_idle4("rstmid.released");
    v4 = 4'hF; d4 = {16'h000C, 16'h000B, 16'h000A, 16'h0009};
    tick();
    v4 = '0;
    for (int k = 0; k < 4; k++) begin
      check("fresh.vld",  vld4,  1'b1);
      check("fresh.data", q4,    16'(k + 9));
      check("fresh.last", last4, (k == 3));
      tick();
    end
    check_idle4("fresh.after");

    // Valid mismatch: bit 0 set drives a capture and raises the sticky error
    v4 = 4'b0111; d4 = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    tick();
    v4 = '0;
    for (int k = 0; k < 4; k++) begin
      check("vmis.err",  err4, 1'b1);
      check("vmis.vld",  vld4, 1'b1);
      check("vmis.data", q4,   16'((k + 1) * 16'h11));
      tick();
    end
    check_idle4("vmis.after");
    // Bit 0 clear: no capture, error stays
    v4 = 4'b1110; d4 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    tick();
    v4 = '0;
    check_idle4("vmis2");
    check("vmis2.err", err4, 1'b1);
    tick(); tick();
    check("vmis2.hold", err4, 1'b1);
    check("vmis2.vld",  vld4, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("vmis.rst.err", err4, 1'b0);
    tick();

    // Long frame on the 30-word instance
    check("n30.idle.vld",  vld30, 1'b0);
    check("n30.idle.data", q30,   16'h0);
    for (int i = 0; i < 30; i++) begin
      words30[i] = 16'($urandom);
      d30[i*16 +: 16] = words30[i];
    end
    v30 = '1;
    tick();
    v30 = '0;
    d30 = '0;
    for (int k = 0; k < 30; k++) begin
      check("n30.vld",  vld30,  1'b1);
      check("n30.data", q30,    words30[k]);
      check("n30.last", last30, (k == 29));
      check("n30.busy", busy30, 1'b1);
      tick();
    end
    check("n30.after.vld",  vld30,  1'b0);
    check("n30.after.data", q30,    16'h0);
    check("n30.after.busy", busy30, 1'b0);
    check("n30.err",        err30,  1'b0);
    check("n30.ovr",        ovr30,  1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
